// File: rtl/serial_rx_buffered_pkg.sv
// Shared types and frame constants for the clock-forwarded serial receiver.
// Imported by the interface, the FIFO and the top level.
package serial_rx_buffered_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } rx_state_e;

   localparam logic        START_BIT = 1'b1;
   localparam int unsigned DATA_BITS = 8;

   typedef logic [DATA_BITS-1:0] byte_t;

   // Occupancy counter must represent 0..DEPTH inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/serial_rx_buffered_if.sv
// Byte-stream handshake between the receiver FIFO head and its consumer.
// master = receiver side, slave = consumer side.
interface serial_rx_buffered_if #(
   parameter int unsigned DEPTH = 4
);
   import serial_rx_buffered_pkg::*;

   byte_t                           PDout;
   logic                            PDvalid;
   logic                            PDaccept;
   logic [count_width(DEPTH)-1:0]   Count;

   modport master (
      output PDout,
      output PDvalid,
      output Count,
      input  PDaccept
   );

   modport slave (
      input  PDout,
      input  PDvalid,
      input  Count,
      output PDaccept
   );

endinterface

// File: rtl/serial_rx_fifo.sv
// Small byte FIFO with occupancy count; full/empty derive from the count so
// the naturally wrapping pointers never need an extra lap bit.
module serial_rx_fifo
   import serial_rx_buffered_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          wr_en,
   input  byte_t                         wr_data,
   input  logic                          rd_en,
   output byte_t                         rd_data,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = count_width(DEPTH);

   byte_t             mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_wr;
   logic              do_rd;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A write into a full FIFO is allowed when the head leaves on the same edge.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/serial_rx_buffered.sv
// Serial receiver: start-bit detect, MSB-first byte assembly with optional
// even parity, and a FIFO-buffered valid/accept output.
module serial_rx_buffered
   import serial_rx_buffered_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter bit          PARITY_EN = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  SDin,
   serial_rx_buffered_if.master  out_if,
   output logic                  Overrun,
   output logic                  ParErr
);

   localparam int unsigned CNT_W = count_width(DEPTH);

   rx_state_e   state_q, state_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   byte_t       shift_q, shift_d;
   logic        overrun_q, overrun_d;
   logic        parerr_q, parerr_d;

   logic        wr_en;
   byte_t       wr_data;
   logic        rd_en;
   byte_t       rd_data;
   logic [CNT_W-1:0] fifo_count;
   logic        fifo_full;
   logic        fifo_empty;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         overrun_q <= 1'b0;
         parerr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         overrun_q <= overrun_d;
         parerr_q  <= parerr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      wr_en    = 1'b0;
      wr_data  = shift_q;
      parerr_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (SDin == START_BIT) begin
               state_d  = DATA;
               bitcnt_d = '0;
            end
         end
         DATA: begin
            shift_d  = {shift_q[DATA_BITS-2:0], SDin};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'(DATA_BITS - 1)) begin
               if (PARITY_EN) begin
                  state_d = PAR;
               end else begin
                  // The pushed byte includes the bit sampled on this edge.
                  wr_en   = 1'b1;
                  wr_data = shift_d;
                  state_d = IDLE;
               end
            end
         end
         PAR: begin
            state_d = IDLE;
            if (^{shift_q, SDin}) parerr_d = 1'b1;
            else                  wr_en    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_en     = out_if.PDaccept & ~fifo_empty;
   assign overrun_d = wr_en & fifo_full & ~rd_en;

   serial_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk     (Clk),
      .Rst     (Rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_if.PDout   = rd_data;
   assign out_if.PDvalid = ~fifo_empty;
   assign out_if.Count   = fifo_count;
   assign Overrun        = overrun_q;
   assign ParErr         = parerr_q;

endmodule

// File: tb/tb_serial_rx_buffered.sv
// Directed bench for serial_rx_buffered: one DUT without parity, one with.
// Bits are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_rx_buffered;

   logic Clk = 1'b0;
   logic Rst;
   logic sd0, sd1;
   logic ov0, pe0, ov1, pe1;

   int total = 0;
   int bad   = 0;
   int ov0_n, pe0_n, ov1_n, pe1_n;
   int max0;
   logic [7:0] rxq [$];

   serial_rx_buffered_if #(.DEPTH(4)) if0 ();
   serial_rx_buffered_if #(.DEPTH(4)) if1 ();

   serial_rx_buffered #(.DEPTH(4), .PARITY_EN(1'b0)) dut0 (
      .Clk(Clk), .Rst(Rst), .SDin(sd0), .out_if(if0.master),
      .Overrun(ov0), .ParErr(pe0)
   );

   serial_rx_buffered #(.DEPTH(4), .PARITY_EN(1'b1)) dut1 (
      .Clk(Clk), .Rst(Rst), .SDin(sd1), .out_if(if1.master),
      .Overrun(ov1), .ParErr(pe1)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // One edge on dut0; a head byte offered with accept=1 is logged as consumed.
   task automatic bit0(input logic b);
      if (if0.PDvalid === 1'b1 && if0.PDaccept === 1'b1) rxq.push_back(if0.PDout);
      sd0 = b;
      @(posedge Clk);
      #1;
      if (ov0 === 1'b1) ov0_n++;
      if (pe0 === 1'b1) pe0_n++;
      if (int'(if0.Count) > max0) max0 = int'(if0.Count);
   endtask

   task automatic bit1(input logic b);
      sd1 = b;
      @(posedge Clk);
      #1;
      if (ov1 === 1'b1) ov1_n++;
      if (pe1 === 1'b1) pe1_n++;
   endtask

   task automatic frame0(input logic [7:0] d);
      bit0(1'b1);
      for (int i = 7; i >= 0; i--) bit0(d[i]);
      sd0 = 1'b0;
   endtask

   task automatic frame1(input logic [7:0] d, input logic p);
      bit1(1'b1);
      for (int i = 7; i >= 0; i--) bit1(d[i]);
      bit1(p);
      sd1 = 1'b0;
   endtask

   task automatic pop0();
      if0.PDaccept = 1'b1;
      bit0(1'b0);
      if0.PDaccept = 1'b0;
   endtask

   task automatic pop1();
      if1.PDaccept = 1'b1;
      bit1(1'b0);
      if1.PDaccept = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (if0.PDvalid !== 1'b0) begin bad++; $display("FAIL reset_valid: actual=%b required=0", if0.PDvalid); end
      total++; if (if0.PDout !== 8'h00) begin bad++; $display("FAIL reset_pdout: actual=%h required=00", if0.PDout); end
      total++; if (if0.Count !== 3'd0) begin bad++; $display("FAIL reset_count: actual=%0d required=0", if0.Count); end
      total++; if (ov0 !== 1'b0 || pe0 !== 1'b0) begin bad++; $display("FAIL reset_pulses: actual=%b%b required=00", ov0, pe0); end
      total++; if (if1.Count !== 3'd0) begin bad++; $display("FAIL reset_count1: actual=%0d required=0", if1.Count); end
      Rst = 1'b0;
   endtask

   task automatic test_reset_midframe();
      ov0_n = 0; pe0_n = 0;
      bit0(1'b1); bit0(1'b1); bit0(1'b0); bit0(1'b1); bit0(1'b0);
      Rst = 1'b1;
      #3;
      Rst = 1'b0;
      sd0 = 1'b0;
      bit0(1'b0);
      frame0(8'hA5);
      total++; if (if0.Count !== 3'd1) begin bad++; $display("FAIL midrst_count: actual=%0d required=1", if0.Count); end
      total++; if (if0.PDout !== 8'hA5) begin bad++; $display("FAIL midrst_pdout: actual=%h required=a5", if0.PDout); end
      total++; if (ov0_n != 0 || pe0_n != 0) begin bad++; $display("FAIL midrst_pulses: actual=%0d/%0d required=0/0", ov0_n, pe0_n); end
      pop0();
      total++; if (if0.Count !== 3'd0) begin bad++; $display("FAIL midrst_drain: actual=%0d required=0", if0.Count); end
   endtask

   task automatic test_latency();
      logic [7:0] d;
      d = 8'hA5;
      bit0(1'b1);
      for (int i = 7; i >= 1; i--) bit0(d[i]);
      total++; if (if0.PDvalid !== 1'b0) begin bad++; $display("FAIL lat_edge8: actual=%b required=0", if0.PDvalid); end
      bit0(d[0]);
      sd0 = 1'b0;
      total++; if (if0.PDvalid !== 1'b1) begin bad++; $display("FAIL lat_edge9: actual=%b required=1", if0.PDvalid); end
      total++; if (if0.PDout !== 8'hA5) begin bad++; $display("FAIL lat_pdout: actual=%h required=a5", if0.PDout); end
      total++; if (if0.Count !== 3'd1) begin bad++; $display("FAIL lat_count: actual=%0d required=1", if0.Count); end
      bit0(1'b0);
      total++; if (if0.PDout !== 8'hA5 || if0.Count !== 3'd1) begin bad++; $display("FAIL lat_hold: actual=%h/%0d required=a5/1", if0.PDout, if0.Count); end
      pop0();
   endtask

   task automatic test_back_to_back();
      rxq.delete();
      max0 = 0; ov0_n = 0;
      if0.PDaccept = 1'b1;
      frame0(8'h3C);
      frame0(8'hC3);
      bit0(1'b0);
      if0.PDaccept = 1'b0;
      total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_size: actual=%0d required=2", rxq.size()); end
      total++; if (rxq.size() < 1 || rxq[0] !== 8'h3C) begin bad++; $display("FAIL b2b_first: actual=%h required=3c", (rxq.size() > 0) ? rxq[0] : 8'hxx); end
      total++; if (rxq.size() < 2 || rxq[1] !== 8'hC3) begin bad++; $display("FAIL b2b_second: actual=%h required=c3", (rxq.size() > 1) ? rxq[1] : 8'hxx); end
      total++; if (max0 > 1) begin bad++; $display("FAIL b2b_maxcount: actual=%0d required<=1", max0); end
      total++; if (ov0_n != 0) begin bad++; $display("FAIL b2b_overrun: actual=%0d required=0", ov0_n); end
      total++; if (if0.Count !== 3'd0) begin bad++; $display("FAIL b2b_count: actual=%0d required=0", if0.Count); end
   endtask

   task automatic test_overrun();
      ov0_n = 0;
      for (int k = 1; k <= 4; k++) frame0(8'(k));
      total++; if (if0.Count !== 3'd4) begin bad++; $display("FAIL ovr_full: actual=%0d required=4", if0.Count); end
      total++; if (ov0_n != 0) begin bad++; $display("FAIL ovr_early: actual=%0d required=0", ov0_n); end
      frame0(8'h05);
      bit0(1'b0);
      total++; if (ov0_n != 1) begin bad++; $display("FAIL ovr_pulse: actual=%0d required=1", ov0_n); end
      total++; if (if0.Count !== 3'd4) begin bad++; $display("FAIL ovr_count: actual=%0d required=4", if0.Count); end
      for (int k = 1; k <= 4; k++) begin
         total++; if (if0.PDout !== 8'(k)) begin bad++; $display("FAIL ovr_drain%0d: actual=%h required=%h", k, if0.PDout, 8'(k)); end
         pop0();
      end
      total++; if (if0.Count !== 3'd0 || if0.PDvalid !== 1'b0) begin bad++; $display("FAIL ovr_empty: actual=%0d/%b required=0/0", if0.Count, if0.PDvalid); end
   endtask

   task automatic test_full_pop();
      logic [7:0] d;
      d = 8'h05;
      ov0_n = 0;
      for (int k = 1; k <= 4; k++) frame0(8'(k));
      rxq.delete();
      bit0(1'b1);
      for (int i = 7; i >= 1; i--) bit0(d[i]);
      if0.PDaccept = 1'b1;
      bit0(d[0]);
      if0.PDaccept = 1'b0;
      sd0 = 1'b0;
      bit0(1'b0);
      total++; if (rxq.size() != 1 || rxq[0] !== 8'h01) begin bad++; $display("FAIL fpop_popped: actual=%0d entries required=1 entry of 01", rxq.size()); end
      total++; if (if0.Count !== 3'd4) begin bad++; $display("FAIL fpop_count: actual=%0d required=4", if0.Count); end
      total++; if (ov0_n != 0) begin bad++; $display("FAIL fpop_overrun: actual=%0d required=0", ov0_n); end
      for (int k = 2; k <= 5; k++) begin
         total++; if (if0.PDout !== 8'(k)) begin bad++; $display("FAIL fpop_drain%0d: actual=%h required=%h", k, if0.PDout, 8'(k)); end
         pop0();
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      d = 8'h0F;
      pe1_n = 0; ov1_n = 0;
      bit1(1'b1);
      for (int i = 7; i >= 0; i--) bit1(d[i]);
      total++; if (if1.PDvalid !== 1'b0) begin bad++; $display("FAIL par_edge9: actual=%b required=0", if1.PDvalid); end
      bit1(1'b0);
      sd1 = 1'b0;
      total++; if (if1.PDvalid !== 1'b1) begin bad++; $display("FAIL par_edge10: actual=%b required=1", if1.PDvalid); end
      total++; if (if1.PDout !== 8'h0F || if1.Count !== 3'd1) begin bad++; $display("FAIL par_good: actual=%h/%0d required=0f/1", if1.PDout, if1.Count); end
      frame1(8'h0F, 1'b1);
      bit1(1'b0);
      total++; if (pe1_n != 1) begin bad++; $display("FAIL par_errpulse: actual=%0d required=1", pe1_n); end
      total++; if (if1.Count !== 3'd1) begin bad++; $display("FAIL par_errcount: actual=%0d required=1", if1.Count); end
      frame1(8'h07, 1'b1);
      total++; if (if1.Count !== 3'd2 || pe1_n != 1) begin bad++; $display("FAIL par_odd: actual=%0d/%0d required=2/1", if1.Count, pe1_n); end
      total++; if (ov1_n != 0) begin bad++; $display("FAIL par_overrun: actual=%0d required=0", ov1_n); end
      total++; if (if1.PDout !== 8'h0F) begin bad++; $display("FAIL par_head0: actual=%h required=0f", if1.PDout); end
      pop1();
      total++; if (if1.PDout !== 8'h07) begin bad++; $display("FAIL par_head1: actual=%h required=07", if1.PDout); end
      pop1();
      total++; if (if1.Count !== 3'd0) begin bad++; $display("FAIL par_drain: actual=%0d required=0", if1.Count); end
   endtask

   initial begin
      Rst = 1'b1;
      sd0 = 1'b0;
      sd1 = 1'b0;
      if0.PDaccept = 1'b0;
      if1.PDaccept = 1'b0;
      ov0_n = 0; pe0_n = 0; ov1_n = 0; pe1_n = 0; max0 = 0;
      repeat (2) @(posedge Clk);
      #1;
      test_reset();
      bit0(1'b0);
      test_reset_midframe();
      test_latency();
      test_back_to_back();
      test_overrun();
      test_full_pop();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
